exe_result_buffer: RTL

EXE_RESULT_BUFFER -- requirements
Module: exe_result_buffer

---
 rtl/exe_result_buffer_pkg.sv | 11 +
 rtl/exe_result_fifo_mem.sv | 26 ++
 rtl/exe_result_buffer.sv | 105 ++++++++++
 3 files changed

// File: rtl/exe_result_buffer_pkg.sv
// Shared execute-stage defines: default field widths and execution-flag bit positions.
package exe_result_buffer_pkg;

    localparam int SIZE_DATA         = 32;
    localparam int SIZE_PHYSICAL_LOG = 6;
    localparam int EXECUTION_FLAGS   = 6;

    localparam int FLAG_EXC_BIT      = 1;
    localparam int FLAG_EXECUTED_BIT = 2;

endpackage

// File: rtl/exe_result_fifo_mem.sv
// Result storage: DEPTH x WIDTH register array, one synchronous write port, one async read port.
module exe_result_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 44,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    // Contents are deliberately not reset; the control logic masks them while empty.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/exe_result_buffer.sv
// Execute-to-writeback result FIFO with flush, occupancy count and head exception flag.
module exe_result_buffer
    import exe_result_buffer_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int DATA_W  = SIZE_DATA,
    parameter int TAG_W   = SIZE_PHYSICAL_LOG,
    parameter int FLAGS_W = EXECUTION_FLAGS
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       valid_i,
    input  logic [DATA_W-1:0]          result_i,
    input  logic [FLAGS_W-1:0]         flags_i,
    input  logic [TAG_W-1:0]           tag_i,
    output logic                       ready_o,
    output logic                       wb_valid_o,
    output logic [DATA_W-1:0]          wb_data_o,
    output logic [FLAGS_W-1:0]         wb_flags_o,
    output logic [TAG_W-1:0]           wb_tag_o,
    input  logic                       wb_ready_i,
    output logic                       exc_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_W + FLAGS_W + TAG_W;

    // Handshake: a transfer happens on a rising edge when valid and ready are both high
    // and flush_i is low; ready_o and wb_valid_o depend only on registered occupancy.
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic          push, pop;
    logic [EW-1:0] rd_entry;

    assign ready_o    = (count_q < CW'(DEPTH));
    assign wb_valid_o = (count_q != '0);
    assign push       = valid_i && ready_o && !flush_i;
    assign pop        = wb_valid_o && wb_ready_i && !flush_i;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    exe_result_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i ({result_i, flags_i, tag_i}),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    // Stale array contents must never leak out while the buffer is empty.
    always_comb begin
        wb_data_o  = '0;
        wb_flags_o = '0;
        wb_tag_o   = '0;
        if (wb_valid_o) begin
            {wb_data_o, wb_flags_o, wb_tag_o} = rd_entry;
        end
    end

    assign exc_o   = wb_valid_o && wb_flags_o[FLAG_EXC_BIT];
    assign count_o = count_q;

endmodule
